bht_predictor: RTL and testbench

- Branch history table for the pipelined CPU. It gives the fetch stage a taken/not-taken prediction for the current PC.
- In decode it consumes the equality result of the branch comparator. From that it resolves beq/bne, flags mispredictions and trains 2-bit saturating counters.
- It also keeps saturating branch and mispredict statistics counters for the bench and performance analysis.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/sat_counter.sv | 33 +++
 rtl/bht_predictor.sv | 90 +++++++++
 tb/tb_bht_predictor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and the 2-bit saturating transition for the branch predictor
package bp_pkg;

    // 2-bit prediction counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

    function automatic bht_state_t next_state(bht_state_t s, logic taken);
        bht_state_t n;
        n = s;
        if (taken) begin
            if (s != ST) n = bht_state_t'(s + 2'd1);
        end else begin
            if (s != SNT) n = bht_state_t'(s - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit event counter that sticks at all-ones
//   clk_i    rising-edge clock
//   clear_i  synchronous clear (has priority over inc_i)
//   inc_i    count one event
//   count_o  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - branch history table: fetch prediction, decode resolution, training, stats
//   clk, reset                 clock and synchronous active-high reset
//   f_pc / f_pred_taken        fetch PC and its combinational prediction
//   d_valid, d_stall           decode holds a branch / decode stalled
//   d_is_bne, d_eq, d_pc       branch kind, comparator result, branch PC
//   d_pred_taken               prediction carried from fetch
//   d_taken, mispredict        actual outcome and redirect request
//   br_count, mp_count         saturating branch / mispredict statistics
module bht_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 16,
    parameter int INDEX_LSB = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_pc,
    output logic             f_pred_taken,
    input  logic             d_valid,
    input  logic             d_stall,
    input  logic             d_is_bne,
    input  logic             d_eq,
    input  logic [WIDTH-1:0] d_pc,
    input  logic             d_pred_taken,
    output logic             d_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    bht_state_t table_q [ENTRIES];
    bht_state_t table_d [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    bht_state_t       f_state;
    logic             resolve;

    // Only the index field of each PC matters; the rest is dropped on purpose
    // (aliasing between branches sharing an index is accepted).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc, d_pc};

    assign f_idx = f_pc[INDEX_LSB +: IDX_W];
    assign d_idx = d_pc[INDEX_LSB +: IDX_W];

    // Read straight from the registered table: a same-cycle update to this
    // entry is not bypassed, it shows up one cycle later.
    assign f_state      = table_q[f_idx];
    assign f_pred_taken = f_state[1];

    assign resolve    = d_valid & ~d_stall;
    assign d_taken    = d_valid & (d_eq ^ d_is_bne);
    assign mispredict = resolve & (d_taken != d_pred_taken);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (resolve) begin
            table_d[d_idx] = next_state(table_q[d_idx], d_taken);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) table_q[i] <= BHT_RESET_STATE;
            else       table_q[i] <= table_d[i];
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i   (clk),
        .clear_i (reset),
        .inc_i   (resolve),
        .count_o (br_count)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk_i   (clk),
        .clear_i (reset),
        .inc_i   (mispredict),
        .count_o (mp_count)
    );

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - self-checking bench for bht_predictor (default and 4-bit stats builds)
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        d_valid, d_stall, d_is_bne, d_eq, d_pred_taken;
    logic [31:0] d_pc;
    logic        f_pred_taken, d_taken, mispredict;
    logic [15:0] br_count, mp_count;
    logic        f_pred_taken4, d_taken4, mispredict4;
    logic [3:0]  br_count4, mp_count4;

    int tests  = 0;
    int failed = 0;

    // Reference model: per-index strength 0..3 and unbounded event counts.
    int strength [16];
    int n_br;
    int n_mp;

    always #5 clk = ~clk;

    bht_predictor dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .d_valid(d_valid), .d_stall(d_stall), .d_is_bne(d_is_bne), .d_eq(d_eq),
        .d_pc(d_pc), .d_pred_taken(d_pred_taken), .d_taken(d_taken),
        .mispredict(mispredict), .br_count(br_count), .mp_count(mp_count)
    );

    bht_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken4),
        .d_valid(d_valid), .d_stall(d_stall), .d_is_bne(d_is_bne), .d_eq(d_eq),
        .d_pc(d_pc), .d_pred_taken(d_pred_taken), .d_taken(d_taken4),
        .mispredict(mispredict4), .br_count(br_count4), .mp_count(mp_count4)
    );

    function automatic int idx(logic [31:0] pc);
        return int'((pc >> 2) & 32'd15);
    endfunction

    function automatic int sat(int v, int max);
        return (v > max) ? max : v;
    endfunction

    function automatic logic m_taken();
        return d_valid ? (d_eq ^ d_is_bne) : 1'b0;
    endfunction

    function automatic logic m_mispredict();
        return (d_valid && !d_stall) && (m_taken() != d_pred_taken);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) strength[i] = 1;
        n_br = 0;
        n_mp = 0;
    endtask

    // Check combinational outputs mid-cycle, then advance one clock and train the model.
    task automatic step();
        logic exp_t, exp_mp;
        @(negedge clk);
        exp_t  = m_taken();
        exp_mp = m_mispredict();
        chk("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, strength[idx(f_pc)] >= 2});
        chk("d_taken",      {31'd0, d_taken},      {31'd0, exp_t});
        chk("mispredict",   {31'd0, mispredict},   {31'd0, exp_mp});
        chk("br_count",     {16'd0, br_count},     sat(n_br, 65535));
        chk("mp_count",     {16'd0, mp_count},     sat(n_mp, 65535));
        chk("f_pred_taken4", {31'd0, f_pred_taken4}, {31'd0, strength[idx(f_pc)] >= 2});
        chk("br_count4",    {28'd0, br_count4},    sat(n_br, 15));
        chk("mp_count4",    {28'd0, mp_count4},    sat(n_mp, 15));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (d_valid && !d_stall) begin
            if (exp_t) strength[idx(d_pc)] = sat(strength[idx(d_pc)] + 1, 3);
            else if (strength[idx(d_pc)] > 0) strength[idx(d_pc)] -= 1;
            n_br++;
            if (exp_mp) n_mp++;
        end
        #1;
    endtask

    task automatic branch(logic [31:0] pc, logic bne, logic eq, logic pred);
        d_valid = 1'b1; d_stall = 1'b0; d_pc = pc;
        d_is_bne = bne; d_eq = eq; d_pred_taken = pred;
    endtask

    initial begin
        reset = 1'b1; f_pc = '0; d_valid = 1'b0; d_stall = 1'b0;
        d_is_bne = 1'b0; d_eq = 1'b0; d_pc = '0; d_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // Reset state reads
        f_pc = 32'h0;  step();
        f_pc = 32'h3C; step();
        chk("reset_pred_3c", {31'd0, f_pred_taken}, 32'd0);

        // Taken beq trains WNT -> WT and counts a mispredict
        branch(32'h10, 1'b0, 1'b1, 1'b0); step();
        d_valid = 1'b0; f_pc = 32'h10; #1;
        chk("train_pred_10", {31'd0, f_pred_taken}, 32'd1);
        chk("train_br", {16'd0, br_count}, 32'd1);
        chk("train_mp", {16'd0, mp_count}, 32'd1);

        // Saturation at ST, then one not-taken keeps predicting taken
        for (int i = 0; i < 4; i++) begin
            branch(32'h10, 1'b0, 1'b1, 1'b1); step();
        end
        branch(32'h10, 1'b0, 1'b0, 1'b1); step();
        d_valid = 1'b0; #1;
        chk("sat_then_nt_pred", {31'd0, f_pred_taken}, 32'd1);

        // bne with equal operands is not taken; 0x50 aliases 0x10 (index 4)
        branch(32'h50, 1'b1, 1'b1, 1'b1); step();
        d_valid = 1'b0; f_pc = 32'h10; #1;
        chk("alias_pred_10", {31'd0, f_pred_taken}, 32'd0);

        // Stalled mispredicting branch: no effect until the stall drops
        branch(32'h10, 1'b0, 1'b1, 1'b0); d_stall = 1'b1;
        repeat (3) step();
        chk("stall_br_hold", {16'd0, br_count}, 32'd7);
        d_stall = 1'b0; f_pc = 32'h10;
        step();  // collision: model still sees pre-update strength
        d_valid = 1'b0; #1;
        chk("collision_next_pred", {31'd0, f_pred_taken}, 32'd1);
        chk("stall_one_update_br", {16'd0, br_count}, 32'd8);

        // 20 resolves: 4-bit stats stick at 15
        reset = 1'b1; d_valid = 1'b0; step(); reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            branch($urandom & 32'h3C, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        d_valid = 1'b0; #1;
        chk("br_count4_sat", {28'd0, br_count4}, 32'd15);
        chk("br_count_20", {16'd0, br_count}, 32'd20);

        // Reset wins over a same-cycle resolve
        branch(32'h10, 1'b0, 1'b1, 1'b0); f_pc = 32'h10; reset = 1'b1;
        step();
        reset = 1'b0; d_valid = 1'b0; #1;
        chk("rst_prio_br", {16'd0, br_count}, 32'd0);
        chk("rst_prio_mp", {16'd0, mp_count}, 32'd0);
        chk("rst_prio_pred", {31'd0, f_pred_taken}, 32'd0);

        // Randomized traffic over a few hot PCs plus random ones
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: d_pc = 32'h10;
                1: d_pc = 32'h50;
                2: d_pc = 32'h3C;
                default: d_pc = $urandom;
            endcase
            f_pc         = ($urandom_range(0, 1) == 1) ? d_pc : $urandom;
            d_valid      = 1'($urandom);
            d_stall      = ($urandom_range(0, 3) == 0);
            d_is_bne     = 1'($urandom);
            d_eq         = 1'($urandom);
            d_pred_taken = 1'($urandom);
            reset        = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
